// File: rtl/axis_dma_route_switch.sv
// axis_dma_route_switch: TID-routed egress demux with drop, and packet round-robin ingress merge
module axis_dma_route_switch #(
  parameter int DATA_W  = 512,
  parameter int N_PORTS = 2,
  parameter int ID_W    = 3
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [DATA_W-1:0]             s_dma_tdata,
  input  logic [DATA_W/8-1:0]           s_dma_tkeep,
  input  logic                          s_dma_tlast,
  input  logic [ID_W-1:0]               s_dma_tid,
  input  logic                          s_dma_tvalid,
  output logic                          s_dma_tready,
  output logic [DATA_W-1:0]             m_dst_tdata,
  output logic [DATA_W/8-1:0]           m_dst_tkeep,
  output logic                          m_dst_tlast,
  output logic [N_PORTS-1:0]            m_dst_tvalid,
  input  logic [N_PORTS-1:0]            m_dst_tready,
  input  logic [N_PORTS*DATA_W-1:0]     s_src_tdata,
  input  logic [N_PORTS*DATA_W/8-1:0]   s_src_tkeep,
  input  logic [N_PORTS-1:0]            s_src_tlast,
  input  logic [N_PORTS-1:0]            s_src_tvalid,
  output logic [N_PORTS-1:0]            s_src_tready,
  input  logic [N_PORTS-1:0]            s_src_suppress,
  output logic [DATA_W-1:0]             m_mrg_tdata,
  output logic [DATA_W/8-1:0]           m_mrg_tkeep,
  output logic                          m_mrg_tlast,
  output logic                          m_mrg_tvalid,
  output logic [ID_W-1:0]               m_mrg_tid,
  input  logic                          m_mrg_tready,
  output logic [31:0]                   drop_cnt
);
  localparam int KW = DATA_W / 8;
  localparam int NX = 2 ** ID_W;
  localparam logic [1:0] E_IDLE  = 2'd0;
  localparam logic [1:0] E_ROUTE = 2'd1;
  localparam logic [1:0] E_DROP  = 2'd2;

  logic [1:0]        est_q, est_d;
  logic [ID_W-1:0]   dest_q, dest_d;
  logic              evld_q, evld_d, elast_q, elast_d;
  logic [DATA_W-1:0] edat_q, edat_d;
  logic [KW-1:0]     ekeep_q, ekeep_d;
  logic [31:0]       drop_q, drop_d;
  logic [NX-1:0]     dst_rdy;
  logic              e_first, e_oor, e_drop, e_acc, e_load;

  logic              lock_q, lock_d, mvld_q, mvld_d, mlast_q, mlast_d;
  logic [ID_W-1:0]   gnt_q, gnt_d, rr_q, rr_d, mtid_q, mtid_d, sel, pick, cand;
  logic [DATA_W-1:0] mdat_q, mdat_d;
  logic [KW-1:0]     mkeep_q, mkeep_d;
  logic [NX-1:0]     src_v, src_l, elig;
  logic              any, go, i_acc;

  // Egress: route/drop decision on the first beat, route held in dest_q until tlast
  always_comb begin
    dst_rdy = NX'(m_dst_tready);
    e_first = est_q == E_IDLE;
    e_oor = {1'b0, s_dma_tid} >= (ID_W+1)'(N_PORTS);
    e_drop = est_q == E_DROP || (e_first && e_oor);
    s_dma_tready = aresetn && (e_drop || !evld_q || dst_rdy[dest_q]);
    e_acc = s_dma_tvalid && s_dma_tready;
    e_load = e_acc && !e_drop;
    est_d = !e_acc ? est_q : s_dma_tlast ? E_IDLE : e_first ? (e_oor ? E_DROP : E_ROUTE) : est_q;
    dest_d = e_load && e_first ? s_dma_tid : dest_q;
    evld_d = e_load || (evld_q && !dst_rdy[dest_q]);
    edat_d = e_load ? s_dma_tdata : edat_q;
    ekeep_d = e_load ? s_dma_tkeep : ekeep_q;
    elast_d = e_load ? s_dma_tlast : elast_q;
    drop_d = e_acc && e_first && e_oor && drop_q != '1 ? drop_q + 32'd1 : drop_q;
  end

  // Ingress: first eligible source at or after rr_q wins in idle; grant held until tlast
  always_comb begin
    src_v = NX'(s_src_tvalid);
    src_l = NX'(s_src_tlast);
    elig = NX'(s_src_tvalid & ~s_src_suppress);
    pick = rr_q;
    cand = '0;
    any = 1'b0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_q) + k) % N_PORTS);
      if (elig[cand]) begin
        pick = cand;
        any = 1'b1;
      end
    end
    sel = lock_q ? gnt_q : pick;
    go = aresetn && (!mvld_q || m_mrg_tready) && (lock_q || any);
    s_src_tready = N_PORTS'({{(NX-1){1'b0}}, go} << sel);
    i_acc = go && src_v[sel];
    gnt_d = i_acc ? sel : gnt_q;
    lock_d = i_acc ? !src_l[sel] : lock_q;
    rr_d = i_acc && src_l[sel] ? (sel == ID_W'(N_PORTS - 1) ? '0 : sel + 1'b1) : rr_q;
    mvld_d = i_acc || (mvld_q && !m_mrg_tready);
    mdat_d = i_acc ? s_src_tdata[int'(sel)*DATA_W +: DATA_W] : mdat_q;
    mkeep_d = i_acc ? s_src_tkeep[int'(sel)*KW +: KW] : mkeep_q;
    mlast_d = i_acc ? src_l[sel] : mlast_q;
    mtid_d = i_acc ? sel : mtid_q;
  end

  // Egress state and output register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      est_q <= E_IDLE;
      dest_q <= '0;
      evld_q <= 1'b0;
      edat_q <= '0;
      ekeep_q <= '0;
      elast_q <= 1'b0;
      drop_q <= '0;
    end else begin
      est_q <= est_d;
      dest_q <= dest_d;
      evld_q <= evld_d;
      edat_q <= edat_d;
      ekeep_q <= ekeep_d;
      elast_q <= elast_d;
      drop_q <= drop_d;
    end
  end

  // Ingress arbiter state and output register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock_q <= 1'b0;
      gnt_q <= '0;
      rr_q <= '0;
      mvld_q <= 1'b0;
      mdat_q <= '0;
      mkeep_q <= '0;
      mlast_q <= 1'b0;
      mtid_q <= '0;
    end else begin
      lock_q <= lock_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      mvld_q <= mvld_d;
      mdat_q <= mdat_d;
      mkeep_q <= mkeep_d;
      mlast_q <= mlast_d;
      mtid_q <= mtid_d;
    end
  end

  assign m_dst_tvalid = N_PORTS'({{(NX-1){1'b0}}, evld_q} << dest_q);
  assign m_dst_tdata = edat_q;
  assign m_dst_tkeep = ekeep_q;
  assign m_dst_tlast = elast_q;
  assign m_mrg_tvalid = mvld_q;
  assign m_mrg_tdata = mdat_q;
  assign m_mrg_tkeep = mkeep_q;
  assign m_mrg_tlast = mlast_q;
  assign m_mrg_tid = mtid_q;
  assign drop_cnt = drop_q;
endmodule
